bus_source_arbiter: RTL and testbench
=====================================

Name: bus_source_arbiter

Overview:
- Shares one 8-bit result bus between N_SRC flag-gated sources.
- Each source only drives non-zero data while its gate flag is high. This block generates those flags one-hot and OR-combines the gated words.
- Registers the selected word into a valid/ready output slot for the downstream sink.
- Arbitration is round-robin, with optional bounded bus locking per requester.

Parameters:
- N_SRC, 4, number of requesters/sources (2..8).
- WIDTH, 8, data width of each source and of the bus.
- MAX_HOLD, 4, maximum consecutive beats one owner may transfer under lock (1..15).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_SRC  per-source bus request, level-sensitive.
- lock  input  N_SRC  per-source request to keep the bus for consecutive beats.
- src_data  input  N_SRC*WIDTH  raw source words; source i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  N_SRC  one-hot gate flags, registered; drives each source's flag.
- bus_out  output  WIDTH  registered bus word.
- bus_valid  output  1  bus_out holds an unconsumed beat.
- bus_owner  output  3  index of the source that produced bus_out.
- sink_ready  input  1  downstream accepts bus_out this cycle.

Behaviour:
- Reset (sync, high) values:
  - gnt=0, bus_out=0, bus_valid=0, bus_owner=0.
  - last_owner=N_SRC-1, so source 0 wins first.
  - beat_cnt=0, state=IDLE.
- Reset asserted mid-transfer discards any pending beat. No partial state survives.
- Gated bus is combinational: gbus = OR over i of (gnt[i] ? src_data[i] : 0). With gnt=0, gbus=0.
- Output slot is free when (!bus_valid || sink_ready). A beat "fires" when the state is GRANT, req[owner]=1 and the slot is free.
- State IDLE:
  - If req==0, stay; gnt=0.
  - Otherwise pick the first set req bit searching last_owner+1, last_owner+2, … with wrap modulo N_SRC.
  - Next cycle: gnt=onehot(pick), owner=pick, beat_cnt=0, state=GRANT.
- State GRANT:
  - On a fire, next cycle: bus_out=gbus, bus_owner=owner, bus_valid=1, beat_cnt+1.
  - Continue (stay GRANT, gnt unchanged) if lock[owner] && req[owner] && beat_cnt+1 < MAX_HOLD. Otherwise release.
  - If req[owner]=0 (with or without lock), release immediately with no beat.
  - If the slot is not free (backpressure), hold gnt and beat_cnt; no data is lost.
  - Release: gnt=0, last_owner=owner, state=IDLE. Release is in the same edge as the final beat.
- Output consumption: if bus_valid && sink_ready and no fire, then bus_valid=0 next cycle. A fire and a consume in the same cycle keep bus_valid=1 with new data (back-to-back).
- Latency: req rises in IDLE at edge t → gnt at t+1 → bus_valid at t+2 (slot free). Each grant costs one IDLE arbitration cycle.
- Non-locked throughput is 1 beat per 2 cycles. Locked throughput is 1 beat/cycle for up to MAX_HOLD beats.
- Fairness: a requester holding req is granted within N_SRC-1 other grants. Lock cannot exceed MAX_HOLD beats.
- Requests arriving while in GRANT wait for release; no preemption.
- req bits for indices ≥ N_SRC do not exist. bus_owner is zero-extended to 3 bits.

Decomposition:
- Shared package:
  - state encoding (IDLE=1'b0, GRANT=1'b1);
  - localparam OWNER_W=3;
  - the round-robin pick function (rotate, priority-encode, rotate back).
- Sub-module bus_gate_or (params N_SRC, WIDTH): one flag-gated source per index, OR-reduced into gbus. Purely combinational.
- Everything else (FSM, counters, output slot) stays in bus_source_arbiter.

Test Plan:
- Reset then req=4'b0001, sink_ready=1, src_data[0]=8'hA5 → gnt=0001 at cycle 1, bus_out=A5, bus_valid=1, bus_owner=0 at cycle 2, gnt=0 at cycle 2.
- req=4'b1111 held, no lock, sink_ready=1, src_data[i]=8'h10+i → bus_owner sequence 0,1,2,3,0 with bus_out 10,11,12,13,10; one beat every 2 cycles.
- req=lock=4'b0100, src_data[2]=8'h3C, MAX_HOLD=4 → exactly 4 consecutive beats with bus_owner=2, then one IDLE cycle, then 4 more.
- Grant to source 1, sink_ready=0 for 3 cycles with bus_valid=1 → gnt, bus_out and bus_valid frozen; beat count unchanged; first beat delivered intact after ready returns.
- Locked owner 3 drops req after 2 beats with req[0]=1 → release without a third beat; next grant goes to source 0; bus_out never shows a zero beat.
- Reset asserted while in GRANT with bus_valid=1 → next cycle gnt=0, bus_valid=0, bus_out=0; the first post-reset grant goes to source 0.

Source files
------------

// File: rtl/bus_source_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus source arbiter.
// Holds the FSM encoding, the owner index width and the round-robin pick.
package bus_source_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int OWNER_W = 3;

    // Rotate requests so the slot after 'last' sits at bit 0, take the lowest
    // set bit, then rotate the found index back into source numbering.
    function automatic logic [OWNER_W-1:0] rr_pick(
        input logic [7:0]         req,
        input logic [OWNER_W-1:0] last,
        input int                 n
    );
        logic [7:0]         rot;
        logic [OWNER_W-1:0] first;
        logic               found;
        int                 idx;
        rot   = '0;
        first = '0;
        found = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j < n) begin
                idx    = (int'(last) + 1 + j) % n;
                rot[j] = req[idx[2:0]];
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                first = OWNER_W'(j);
            end
        end
        idx = (int'(last) + 1 + int'(first)) % n;
        return OWNER_W'(idx);
    endfunction

endpackage

// File: rtl/bus_source_arbiter_gate_or.sv
// Flag-gated source words OR-reduced onto one shared bus.
// Purely combinational; with no flag raised the bus reads zero.
module bus_gate_or
    import bus_source_arbiter_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int WIDTH = 8
) (
    input  logic [N_SRC-1:0]       gnt,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    output logic [WIDTH-1:0]       gbus
);

    always_comb begin
        gbus = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                gbus = gbus | src_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter sharing one gated bus among N_SRC sources, with bounded
// per-owner locking and a registered valid/ready output slot.
module bus_source_arbiter
    import bus_source_arbiter_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC-1:0]       lock,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    output logic [N_SRC-1:0]       gnt,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid,
    output logic [OWNER_W-1:0]     bus_owner,
    input  logic                   sink_ready
);

    state_t             state, state_nxt;
    logic [OWNER_W-1:0] owner, owner_nxt;
    logic [OWNER_W-1:0] last_owner, last_owner_nxt;
    logic [3:0]         beat_cnt, beat_cnt_nxt;
    logic [N_SRC-1:0]   gnt_nxt;
    logic [WIDTH-1:0]   bus_out_nxt;
    logic               bus_valid_nxt;
    logic [OWNER_W-1:0] bus_owner_nxt;

    logic [WIDTH-1:0]   gbus;
    logic [7:0]         req_ext, lock_ext;
    logic [OWNER_W-1:0] pick;
    logic               slot_free, hold_ok;

    bus_gate_or #(
        .N_SRC (N_SRC),
        .WIDTH (WIDTH)
    ) u_gate_or (
        .gnt      (gnt),
        .src_data (src_data),
        .gbus     (gbus)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OWNER_W'(N_SRC - 1);
            beat_cnt   <= '0;
            gnt        <= '0;
            bus_out    <= '0;
            bus_valid  <= 1'b0;
            bus_owner  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
            gnt        <= gnt_nxt;
            bus_out    <= bus_out_nxt;
            bus_valid  <= bus_valid_nxt;
            bus_owner  <= bus_owner_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        gnt_nxt        = gnt;
        bus_out_nxt    = bus_out;
        bus_valid_nxt  = bus_valid;
        bus_owner_nxt  = bus_owner;

        req_ext                = '0;
        lock_ext               = '0;
        req_ext[N_SRC-1:0]     = req;
        lock_ext[N_SRC-1:0]    = lock;
        pick                   = rr_pick(req_ext, last_owner, N_SRC);
        slot_free              = !bus_valid || sink_ready;
        hold_ok                = ({1'b0, beat_cnt} + 5'd1) < 5'(MAX_HOLD);

        if (bus_valid && sink_ready) begin
            bus_valid_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (|req) begin
                    gnt_nxt      = {{(N_SRC-1){1'b0}}, 1'b1} << pick;
                    owner_nxt    = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (!req_ext[owner]) begin
                    gnt_nxt        = '0;
                    last_owner_nxt = owner;
                    state_nxt      = IDLE;
                end else if (slot_free) begin
                    bus_out_nxt   = gbus;
                    bus_owner_nxt = owner;
                    bus_valid_nxt = 1'b1;
                    beat_cnt_nxt  = beat_cnt + 4'd1;
                    // Release shares the edge with the final beat of a tenure.
                    if (!(lock_ext[owner] && hold_ok)) begin
                        gnt_nxt        = '0;
                        last_owner_nxt = owner;
                        state_nxt      = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed self-checking bench for bus_source_arbiter (N_SRC=4, WIDTH=8, MAX_HOLD=4).
module tb_bus_source_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, lock, gnt;
    logic [31:0] src_data;
    logic [7:0]  bus_out;
    logic        bus_valid, sink_ready;
    logic [2:0]  bus_owner;

    int n_tests = 0;
    int n_fail  = 0;

    bus_source_arbiter #(.N_SRC(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .src_data   (src_data),
        .gnt        (gnt),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .bus_owner  (bus_owner),
        .sink_ready (sink_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; lock = '0; sink_ready = 1'b1; src_data = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; lock = '0; sink_ready = 1'b1; src_data = 32'hFFFF_FFFF;
        tick(); tick();
        if ({gnt, bus_out, bus_valid, bus_owner} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_values: got gnt=%b out=%h v=%b own=%0d want all zero", gnt, bus_out, bus_valid, bus_owner);
        end
        n_tests++;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; src_data[7:0] = 8'hA5;
        tick();
        if (gnt !== 4'b0001 || bus_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_grant: got gnt=%b v=%b want 0001 0", gnt, bus_valid);
        end
        n_tests++;
        tick();
        if (bus_out !== 8'hA5 || bus_valid !== 1'b1 || bus_owner !== 3'd0 || gnt !== 4'b0000) begin
            n_fail++; $display("FAIL single_beat: got out=%h v=%b own=%0d gnt=%b want a5 1 0 0000", bus_out, bus_valid, bus_owner, gnt);
        end
        n_tests++;
        req = 4'b0000;
        tick();
        if (bus_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_consume: got v=%b want 0", bus_valid);
        end
        n_tests++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            tick();
            if (gnt !== exp_gnt || bus_valid !== 1'b0) begin
                n_fail++; $display("FAIL rr_grant k=%0d: got gnt=%b v=%b want %b 0", k, gnt, bus_valid, exp_gnt);
            end
            n_tests++;
            tick();
            if (bus_valid !== 1'b1 || bus_owner !== 3'(k % 4) || bus_out !== 8'h10 + 8'(k % 4) || gnt !== 4'b0000) begin
                n_fail++; $display("FAIL rr_beat k=%0d: got v=%b own=%0d out=%h gnt=%b want 1 %0d %h 0000",
                                   k, bus_valid, bus_owner, bus_out, gnt, k % 4, 8'h10 + 8'(k % 4));
            end
            n_tests++;
        end
        req = '0;
    endtask

    task automatic test_lock_hold();
        do_reset();
        req = 4'b0100; lock = 4'b0100; src_data[23:16] = 8'h3C;
        for (int r = 0; r < 2; r++) begin
            tick();
            if (gnt !== 4'b0100 || bus_valid !== 1'b0) begin
                n_fail++; $display("FAIL lock_grant r=%0d: got gnt=%b v=%b want 0100 0", r, gnt, bus_valid);
            end
            n_tests++;
            for (int b = 0; b < 4; b++) begin
                tick();
                if (bus_valid !== 1'b1 || bus_owner !== 3'd2 || bus_out !== 8'h3C ||
                    gnt !== ((b < 3) ? 4'b0100 : 4'b0000)) begin
                    n_fail++; $display("FAIL lock_beat r=%0d b=%0d: got v=%b own=%0d out=%h gnt=%b", r, b, bus_valid, bus_owner, bus_out, gnt);
                end
                n_tests++;
            end
        end
        req = '0; lock = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        sink_ready = 1'b0; req = 4'b0011; lock = 4'b0010;
        src_data[7:0] = 8'h40; src_data[15:8] = 8'h41;
        tick(); tick();
        if (bus_valid !== 1'b1 || bus_out !== 8'h40 || bus_owner !== 3'd0) begin
            n_fail++; $display("FAIL bp_first: got v=%b out=%h own=%0d want 1 40 0", bus_valid, bus_out, bus_owner);
        end
        n_tests++;
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            if (gnt !== 4'b0010 || bus_valid !== 1'b1 || bus_out !== 8'h40 || bus_owner !== 3'd0) begin
                n_fail++; $display("FAIL bp_frozen c=%0d: got gnt=%b v=%b out=%h own=%0d want 0010 1 40 0", c, gnt, bus_valid, bus_out, bus_owner);
            end
            n_tests++;
        end
        sink_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            if (bus_valid !== 1'b1 || bus_owner !== 3'd1 || bus_out !== 8'h41 ||
                gnt !== ((b < 3) ? 4'b0010 : 4'b0000)) begin
                n_fail++; $display("FAIL bp_beat b=%0d: got v=%b own=%0d out=%h gnt=%b", b, bus_valid, bus_owner, bus_out, gnt);
            end
            n_tests++;
        end
        req = '0; lock = '0;
    endtask

    task automatic test_lock_drop();
        do_reset();
        req = 4'b1000; lock = 4'b1000;
        src_data[31:24] = 8'h33; src_data[7:0] = 8'h50;
        tick();
        for (int b = 0; b < 2; b++) begin
            tick();
            if (bus_valid !== 1'b1 || bus_owner !== 3'd3 || bus_out !== 8'h33 || gnt !== 4'b1000) begin
                n_fail++; $display("FAIL drop_beat b=%0d: got v=%b own=%0d out=%h gnt=%b", b, bus_valid, bus_owner, bus_out, gnt);
            end
            n_tests++;
        end
        req = 4'b0001;
        tick();
        if (bus_valid !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++; $display("FAIL drop_release: got v=%b gnt=%b want 0 0000", bus_valid, gnt);
        end
        n_tests++;
        tick();
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL drop_next_grant: got gnt=%b want 0001", gnt);
        end
        n_tests++;
        tick();
        if (bus_valid !== 1'b1 || bus_owner !== 3'd0 || bus_out !== 8'h50) begin
            n_fail++; $display("FAIL drop_next_beat: got v=%b own=%0d out=%h want 1 0 50", bus_valid, bus_owner, bus_out);
        end
        n_tests++;
        req = '0; lock = '0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0010; lock = 4'b0010; src_data = 32'h1122_3344;
        tick(); tick();
        if (bus_valid !== 1'b1 || gnt !== 4'b0010 || bus_out !== 8'h33) begin
            n_fail++; $display("FAIL mr_setup: got v=%b gnt=%b out=%h want 1 0010 33", bus_valid, gnt, bus_out);
        end
        n_tests++;
        reset = 1'b1; req = 4'b1111; lock = '0;
        tick();
        if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_out !== 8'h00 || bus_owner !== 3'd0) begin
            n_fail++; $display("FAIL mr_cleared: got gnt=%b v=%b out=%h own=%0d want 0000 0 00 0", gnt, bus_valid, bus_out, bus_owner);
        end
        n_tests++;
        reset = 1'b0;
        tick();
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL mr_first_grant: got gnt=%b want 0001", gnt);
        end
        n_tests++;
        tick();
        if (bus_valid !== 1'b1 || bus_owner !== 3'd0 || bus_out !== 8'h44) begin
            n_fail++; $display("FAIL mr_first_beat: got v=%b own=%0d out=%h want 1 0 44", bus_valid, bus_owner, bus_out);
        end
        n_tests++;
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = '0; lock = '0; sink_ready = 1'b1; src_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_hold();
        test_backpressure();
        test_lock_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
